// File: rtl/sub_serial_pkg.sv
// ============================================================================
// sub_serial_pkg : state encoding and counter sizing for sub_serial
// Revision 1.0
// ============================================================================
`default_nettype none

package sub_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bit counter must represent 0..N inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sub_serial_fa.sv
// ============================================================================
// fa : one-bit full-adder cell
// Revision 1.0
// ============================================================================
`default_nettype none

module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

`default_nettype wire

// File: rtl/sub_serial.sv
// ============================================================================
// sub_serial : bit-serial N-bit subtractor d = a - b - bin, LSB first.
// Optional SUB_SERIAL_SAT_EN: clamp d to 0 on final borrow.  Revision 1.0
// ============================================================================
`default_nettype none

module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         busy,
  output logic         done
);

  localparam int CW = cnt_width(N);

  state_t        state_q, state_d;
  logic [N-1:0]  a_sr_q, a_sr_d;
  logic [N-1:0]  b_sr_q, b_sr_d;
  logic [N-1:0]  res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [N-1:0]  d_q, d_d;
  logic          bout_q, bout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          fa_s, fa_co;
  logic [N-1:0]  s_vec;
  logic [N-1:0]  res_shift;

  fa u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    d_d       = d_q;
    bout_d    = bout_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    s_vec     = '0;
    s_vec[N-1] = fa_s;
    res_shift = (res_q >> 1) | s_vec;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (start) begin
          // Subtraction as a + ~b + ~bin; carry holds the inverted borrow.
          a_sr_d  = a;
          b_sr_d  = ~b;
          carry_d = ~bin;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        res_d   = res_shift;
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          bout_d  = ~fa_co;
`ifdef SUB_SERIAL_SAT_EN
          d_d     = fa_co ? res_shift : '0;
`else
          d_d     = res_shift;
`endif
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign d    = d_q;
  assign bout = bout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sub_serial.sv
// ============================================================================
// tb_sub_serial : directed and random checks of sub_serial at N=4 and N=8
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_sub_serial;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;

  logic       s4 = 1'b0, bin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [3:0] d4;
  logic       bout4, busy4, done4;

  logic       s8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [7:0] d8;
  logic       bout8, busy8, done8;

  int n_tests = 0;
  int n_fail  = 0;
  int dn4 = 0, dn8 = 0;

  always #5 clock = ~clock;

  sub_serial #(.N(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .start(s4), .a(a4), .b(b4), .bin(bin4),
    .d(d4), .bout(bout4), .busy(busy4), .done(done4)
  );

  sub_serial #(.N(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .start(s8), .a(a8), .b(b8), .bin(bin8),
    .d(d8), .bout(bout8), .busy(busy8), .done(done8)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer subtraction, borrow when the result goes negative.
  function automatic void ref_sub(input int n, input int a, input int b, input int bi,
                                  output int dv, output bit bo);
    int diff;
    diff = a - b - bi;
    bo   = (diff < 0);
    dv   = diff & ((1 << n) - 1);
`ifdef SUB_SERIAL_SAT_EN
    if (bo) dv = 0;
`endif
  endfunction

  // Transaction-level model: accept when not busy, publish result N edges later.
  int m4_rem = 0, m4_d = 0, m4_pd = 0;
  bit m4_busy = 0, m4_done = 0, m4_bout = 0, m4_pb = 0;
  int m8_rem = 0, m8_d = 0, m8_pd = 0;
  bit m8_busy = 0, m8_done = 0, m8_bout = 0, m8_pb = 0;

  always @(posedge clock or negedge reset_n) begin : model4
    int pd;
    bit pb;
    if (!reset_n) begin
      m4_rem <= 0; m4_busy <= 0; m4_done <= 0; m4_d <= 0; m4_bout <= 0;
    end else if (m4_busy) begin
      m4_rem <= m4_rem - 1;
      if (m4_rem == 1) begin
        m4_busy <= 0; m4_done <= 1; m4_d <= m4_pd; m4_bout <= m4_pb;
      end else begin
        m4_done <= 0;
      end
    end else begin
      m4_done <= 0;
      if (s4) begin
        ref_sub(4, int'(a4), int'(b4), int'(bin4), pd, pb);
        m4_pd <= pd; m4_pb <= pb; m4_rem <= 4; m4_busy <= 1;
      end
    end
  end

  always @(posedge clock or negedge reset_n) begin : model8
    int pd;
    bit pb;
    if (!reset_n) begin
      m8_rem <= 0; m8_busy <= 0; m8_done <= 0; m8_d <= 0; m8_bout <= 0;
    end else if (m8_busy) begin
      m8_rem <= m8_rem - 1;
      if (m8_rem == 1) begin
        m8_busy <= 0; m8_done <= 1; m8_d <= m8_pd; m8_bout <= m8_pb;
      end else begin
        m8_done <= 0;
      end
    end else begin
      m8_done <= 0;
      if (s8) begin
        ref_sub(8, int'(a8), int'(b8), int'(bin8), pd, pb);
        m8_pd <= pd; m8_pb <= pb; m8_rem <= 8; m8_busy <= 1;
      end
    end
  end

  always @(negedge clock) begin
    chk("m4_d", d4, m4_d);
    chk("m4_bout", bout4, m4_bout);
    chk("m4_busy", busy4, m4_busy);
    chk("m4_done", done4, m4_done);
    chk("m8_d", d8, m8_d);
    chk("m8_bout", bout8, m8_bout);
    chk("m8_busy", busy8, m8_busy);
    chk("m8_done", done8, m8_done);
    if (done4 === 1'b1) dn4++;
    if (done8 === 1'b1) dn8++;
  end

  task automatic start4(input int a, input int b, input int bi);
    s4 = 1'b1; a4 = 4'(a); b4 = 4'(b); bin4 = bi[0];
    @(negedge clock);
    s4 = 1'b0; a4 = 4'hF; b4 = 4'h5; bin4 = 1'b1;
  endtask

  task automatic wait4(output int nb);
    bit ok;
    nb = 0; ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy4) nb++;
      if (done4) begin ok = 1; break; end
      @(negedge clock);
    end
    chk("done4_seen", ok, 1);
  endtask

  task automatic wait8();
    bit ok;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (done8) begin ok = 1; break; end
      @(negedge clock);
    end
    chk("done8_seen", ok, 1);
  endtask

  int e_3_9, e_5_5;

  initial begin
    int nb;
`ifdef SUB_SERIAL_SAT_EN
    e_3_9 = 0;  e_5_5 = 0;
`else
    e_3_9 = 10; e_5_5 = 15;
`endif
    repeat (2) @(negedge clock);
    chk("rst_d", d4, 0);
    chk("rst_bout", bout4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    reset_n = 1'b1;
    @(negedge clock);

    start4(9, 3, 0);  wait4(nb);
    chk("9-3 d", d4, 6); chk("9-3 bout", bout4, 0); chk("9-3 busy_cycles", nb, 4);
    start4(3, 9, 0);  wait4(nb);
    chk("3-9 d", d4, e_3_9); chk("3-9 bout", bout4, 1);
    start4(5, 5, 1);  wait4(nb);
    chk("5-5-1 d", d4, e_5_5); chk("5-5-1 bout", bout4, 1);
    start4(0, 0, 0);  wait4(nb);
    chk("0-0 d", d4, 0); chk("0-0 bout", bout4, 0);

    // Start while busy must be dropped; start on the done cycle must be taken.
    start4(9, 3, 0);
    @(negedge clock);
    s4 = 1'b1; a4 = 4'd15; b4 = 4'd1; bin4 = 1'b0;
    @(negedge clock);
    s4 = 1'b0;
    wait4(nb);
    chk("ignored d", d4, 6);
    start4(15, 1, 0);
    chk("b2b busy", busy4, 1);
    chk("b2b done_low", done4, 0);
    wait4(nb);
    chk("b2b d", d4, 14); chk("b2b bout", bout4, 0);

    // Asynchronous abort mid-operation.
    start4(9, 3, 0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("abort d", d4, 0); chk("abort bout", bout4, 0);
    chk("abort busy", busy4, 0); chk("abort done", done4, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    start4(7, 2, 0);  wait4(nb);
    chk("7-2 d", d4, 5); chk("7-2 bout", bout4, 0);

    for (int i = 0; i < 500; i++) begin
      s8 = 1'b1; a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
      bin8 = 1'($urandom_range(0, 1));
      @(negedge clock);
      s8 = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        s8 = 1'b1; a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
        @(negedge clock);
        s8 = 1'b0;
      end
      wait8();
      if ($urandom_range(0, 1) == 1) @(negedge clock);
    end

    repeat (3) @(negedge clock);
    chk("done_pulses4", dn4, 7);
    chk("done_pulses8", dn8, 500);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
